// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core and
// the protocol controller (pc) with lock, anti-starvation and write guard.
// Ports:
//   clk, nrst (async, active-high)
//   core_req/addr/wdata/wr -> core_gnt, core_rvalid, core_rdata
//   pc_req/addr/wdata/wr/lock -> pc_gnt, pc_rvalid, pc_rdata, pc_err
//   mem_addr/mem_out/mem_wr -> datamem, mem_in <- datamem (1-cycle read)
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        core_req,
    input  logic [10:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wr,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        pc_req,
    input  logic [10:0] pc_addr,
    input  logic [31:0] pc_wdata,
    input  logic [3:0]  pc_wr,
    input  logic        pc_lock,
    output logic        pc_gnt,
    output logic        pc_rvalid,
    output logic [31:0] pc_rdata,
    output logic        pc_err,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_out,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_in
);

    localparam int unsigned CW_RAW = $clog2(STARVE_MAX + 1);
    localparam int unsigned CW = (CW_RAW > 3) ? CW_RAW : 3;
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;
    logic          lock_q, lock_d;
    logic          core_rv_q, core_rv_d;
    logic          pc_rv_q, pc_rv_d;
    logic          pc_err_q, pc_err_d;

    logic          force_pc;
    logic          core_sel;
    logic          pc_sel;
    logic          pc_prot;

    // Grants are masked during reset so the memory sees no access.
    always_comb begin
        force_pc = pc_req & (lock_q | (starve_q == SMAX));
        core_sel = ~nrst & core_req & ~force_pc;
        pc_sel   = ~nrst & pc_req & ~core_sel;
        pc_prot  = (pc_wr != 4'h0) & ~pc_addr[10];
    end

    assign core_gnt = core_sel;
    assign pc_gnt   = pc_sel;

    always_comb begin
        mem_addr = '0;
        mem_out  = '0;
        mem_wr   = '0;
        if (core_sel) begin
            mem_addr = core_addr;
            mem_out  = core_wdata;
            mem_wr   = core_wr;
        end else if (pc_sel) begin
            mem_addr = pc_addr;
            mem_out  = pc_wdata;
            // Protected pc writes are accepted but never reach memory.
            mem_wr   = pc_prot ? 4'h0 : pc_wr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!pc_req || pc_sel) begin
            starve_d = '0;
        end else if (core_sel && (starve_q != SMAX)) begin
            starve_d = starve_q + 1'b1;
        end

        lock_d = lock_q;
        if (!pc_req || !pc_lock) begin
            lock_d = 1'b0;
        end else if (pc_sel) begin
            lock_d = 1'b1;
        end

        core_rv_d = core_sel & (core_wr == 4'h0);
        pc_rv_d   = pc_sel & (pc_wr == 4'h0);
        pc_err_d  = pc_sel & pc_prot;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            starve_q  <= '0;
            lock_q    <= 1'b0;
            core_rv_q <= 1'b0;
            pc_rv_q   <= 1'b0;
            pc_err_q  <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            lock_q    <= lock_d;
            core_rv_q <= core_rv_d;
            pc_rv_q   <= pc_rv_d;
            pc_err_q  <= pc_err_d;
        end
    end

    assign core_rvalid = core_rv_q;
    assign pc_rvalid   = pc_rv_q;
    assign pc_err      = pc_err_q;
    assign core_rdata  = core_rv_q ? mem_in : 32'h0;
    assign pc_rdata    = pc_rv_q ? mem_in : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// priority model checked every negative clock edge.
module tb_dmem_arbiter;

    localparam int SMAX = 4;
    localparam int G_NONE = 0;
    localparam int G_CORE = 1;
    localparam int G_PC = 2;

    logic        clk;
    logic        nrst;
    logic        core_req;
    logic [10:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wr;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        pc_req;
    logic [10:0] pc_addr;
    logic [31:0] pc_wdata;
    logic [3:0]  pc_wr;
    logic        pc_lock;
    logic        pc_gnt;
    logic        pc_rvalid;
    logic [31:0] pc_rdata;
    logic        pc_err;
    logic [10:0] mem_addr;
    logic [31:0] mem_out;
    logic [3:0]  mem_wr;
    logic [31:0] mem_in;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .nrst(nrst),
        .core_req(core_req), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wr(core_wr),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .pc_req(pc_req), .pc_addr(pc_addr), .pc_wdata(pc_wdata),
        .pc_wr(pc_wr), .pc_lock(pc_lock), .pc_gnt(pc_gnt),
        .pc_rvalid(pc_rvalid), .pc_rdata(pc_rdata), .pc_err(pc_err),
        .mem_addr(mem_addr), .mem_out(mem_out), .mem_wr(mem_wr),
        .mem_in(mem_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_in <= $urandom;

    // Model state: consecutive core wins while pc waits, lock ownership,
    // and what the previous cycle's grant promises for this cycle.
    int m_starve;
    bit m_lock;
    bit m_rvc;
    bit m_rvp;
    bit m_err;

    function automatic int grant_of();
        if (pc_req && m_lock) return G_PC;
        if (pc_req && m_starve == SMAX) return G_PC;
        if (core_req) return G_CORE;
        if (pc_req) return G_PC;
        return G_NONE;
    endfunction

    function automatic bit protected_wr();
        return (pc_wr != 4'h0) && (int'(pc_addr) < 1024);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    int g_upd;
    always @(posedge clk or posedge nrst) begin
        if (nrst) begin
            m_starve <= 0;
            m_lock   <= 1'b0;
            m_rvc    <= 1'b0;
            m_rvp    <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            g_upd = grant_of();
            m_rvc <= (g_upd == G_CORE) && (core_wr == 4'h0);
            m_rvp <= (g_upd == G_PC) && (pc_wr == 4'h0);
            m_err <= (g_upd == G_PC) && protected_wr();
            if (g_upd == G_PC || !pc_req) m_starve <= 0;
            else if (g_upd == G_CORE && m_starve < SMAX)
                m_starve <= m_starve + 1;
            if (!pc_req || !pc_lock) m_lock <= 1'b0;
            else if (g_upd == G_PC) m_lock <= 1'b1;
        end
    end

    int g_cmp;
    logic [10:0] e_addr;
    logic [31:0] e_out;
    logic [3:0]  e_wr;
    always @(negedge clk) begin
        if (nrst) begin
            chk("rst_core_gnt", 32'(core_gnt), 0);
            chk("rst_pc_gnt", 32'(pc_gnt), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_out", mem_out, 0);
            chk("rst_mem_wr", 32'(mem_wr), 0);
            chk("rst_core_rvalid", 32'(core_rvalid), 0);
            chk("rst_pc_rvalid", 32'(pc_rvalid), 0);
            chk("rst_core_rdata", core_rdata, 0);
            chk("rst_pc_rdata", pc_rdata, 0);
            chk("rst_pc_err", 32'(pc_err), 0);
        end else begin
            g_cmp = grant_of();
            e_addr = '0;
            e_out = '0;
            e_wr = '0;
            if (g_cmp == G_CORE) begin
                e_addr = core_addr;
                e_out = core_wdata;
                e_wr = core_wr;
            end else if (g_cmp == G_PC) begin
                e_addr = pc_addr;
                e_out = pc_wdata;
                e_wr = protected_wr() ? 4'h0 : pc_wr;
            end
            chk("core_gnt", 32'(core_gnt), 32'(g_cmp == G_CORE));
            chk("pc_gnt", 32'(pc_gnt), 32'(g_cmp == G_PC));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_out", mem_out, e_out);
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("core_rvalid", 32'(core_rvalid), 32'(m_rvc));
            chk("pc_rvalid", 32'(pc_rvalid), 32'(m_rvp));
            chk("core_rdata", core_rdata, m_rvc ? mem_in : 32'h0);
            chk("pc_rdata", pc_rdata, m_rvp ? mem_in : 32'h0);
            chk("pc_err", 32'(pc_err), 32'(m_err));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_core(input logic r, input logic [10:0] a,
                            input logic [31:0] d, input logic [3:0] w);
        core_req = r;
        core_addr = a;
        core_wdata = d;
        core_wr = w;
    endtask

    task automatic drv_pc(input logic r, input logic [10:0] a,
                          input logic [31:0] d, input logic [3:0] w,
                          input logic l);
        pc_req = r;
        pc_addr = a;
        pc_wdata = d;
        pc_wr = w;
        pc_lock = l;
    endtask

    bit pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        nrst = 1'b1;
        drv_core(0, 0, 0, 0);
        drv_pc(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;

        // Core read: same-cycle grant, data one cycle later.
        next();
        drv_core(1, 11'h003, 0, 0);
        @(negedge clk);
        chk("t26_gnt", 32'(core_gnt), 1);
        chk("t26_addr", 32'(mem_addr), 32'h003);
        chk("t26_wr", 32'(mem_wr), 0);
        next();
        drv_core(0, 0, 0, 0);
        @(negedge clk);
        chk("t26_rvalid", 32'(core_rvalid), 1);
        chk("t26_rdata", core_rdata, mem_in);

        // Both requesting: four core grants then a forced pc grant.
        next();
        drv_core(1, 11'h005, 0, 0);
        drv_pc(1, 11'h405, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t27_pc_gnt%0d", i), 32'(pc_gnt), 32'(pat[i]));
            chk($sformatf("t27_core_gnt%0d", i), 32'(core_gnt),
                32'(!pat[i]));
            next();
        end
        drv_core(0, 0, 0, 0);
        drv_pc(0, 0, 0, 0, 0);

        // Lock: pc keeps ownership until the cycle after lock drops.
        next();
        drv_pc(1, 11'h410, 0, 0, 1);
        @(negedge clk);
        chk("t28_first", 32'(pc_gnt), 1);
        next();
        drv_core(1, 11'h007, 0, 0);
        @(negedge clk);
        chk("t28_lock1", 32'(pc_gnt), 1);
        chk("t28_lock1_core", 32'(core_gnt), 0);
        next();
        @(negedge clk);
        chk("t28_lock2", 32'(pc_gnt), 1);
        next();
        pc_lock = 1'b0;
        @(negedge clk);
        chk("t28_drop", 32'(pc_gnt), 1);
        next();
        @(negedge clk);
        chk("t28_core_back", 32'(core_gnt), 1);
        next();
        drv_core(0, 0, 0, 0);
        drv_pc(0, 0, 0, 0, 0);

        // Write protection of the low half for pc writes.
        next();
        drv_pc(1, 11'h002, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        chk("t29_gnt", 32'(pc_gnt), 1);
        chk("t29_wr_blk", 32'(mem_wr), 0);
        chk("t29_err0", 32'(pc_err), 0);
        next();
        drv_pc(1, 11'h401, 32'h12345678, 4'hF, 0);
        @(negedge clk);
        chk("t29_err", 32'(pc_err), 1);
        chk("t29_wr_ok", 32'(mem_wr), 32'hF);
        chk("t29_out", mem_out, 32'h12345678);
        chk("t29_rv", 32'(pc_rvalid), 0);
        next();
        drv_pc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t29_err_clr", 32'(pc_err), 0);

        // Core writes the low half freely.
        next();
        drv_core(1, 11'h002, 32'hA5A5A5A5, 4'h3);
        @(negedge clk);
        chk("core_wr_lo", 32'(mem_wr), 32'h3);
        next();
        drv_core(0, 0, 0, 0);
        @(negedge clk);
        chk("core_wr_norv", 32'(core_rvalid), 0);

        // Asynchronous reset clears a visible rvalid.
        next();
        drv_core(1, 11'h009, 0, 0);
        next();
        drv_core(0, 0, 0, 0);
        #1;
        chk("async_pre", 32'(core_rvalid), 1);
        nrst = 1'b1;
        #1;
        chk("async_rv", 32'(core_rvalid), 0);
        chk("async_rdata", core_rdata, 0);
        @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;

        // Reset pulse inside a read cycle kills the pending rvalid.
        next();
        drv_core(1, 11'h00A, 0, 0);
        #1;
        chk("t30_gnt", 32'(core_gnt), 1);
        #1 nrst = 1'b1;
        #1;
        drv_core(0, 0, 0, 0);
        drv_pc(1, 11'h420, 0, 0, 0);
        nrst = 1'b0;
        @(negedge clk);
        chk("t30_pc_gnt", 32'(pc_gnt), 1);
        chk("t30_rv0", 32'(core_rvalid), 0);
        next();
        drv_pc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t30_rv1", 32'(core_rvalid), 0);
        chk("t30_pc_rv", 32'(pc_rvalid), 1);

        // Mixed traffic, checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            next();
            drv_core(1'($urandom_range(0, 1)), 11'($urandom),
                     $urandom, ($urandom_range(0, 1) != 0) ?
                     4'($urandom) : 4'h0);
            drv_pc(1'($urandom_range(0, 2) != 0), 11'($urandom),
                   $urandom, ($urandom_range(0, 1) != 0) ?
                   4'($urandom) : 4'h0, 1'($urandom_range(0, 3) == 0));
        end
        next();
        drv_core(0, 0, 0, 0);
        drv_pc(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive core grants while pc_req is pending before the protocol side is forced in.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-004 core_req/core_addr/core_wdata/core_wr  input  1/11/32/4  core access request, word address, write data, byte write enables (0 = read).
REQ-005 core_gnt  output  1  core access accepted this cycle.
REQ-006 core_rvalid/core_rdata  output  1/32  core read data valid, read data.
REQ-007 pc_req/pc_addr/pc_wdata/pc_wr/pc_lock  input  1/11/32/4/1  protocol-controller request fields; pc_lock requests back-to-back ownership.
REQ-008 pc_gnt, pc_rvalid, pc_rdata, pc_err  output  1,1,32,1  pc grant, read valid, read data, write-protection violation pulse.
REQ-009 mem_addr/mem_out/mem_wr  output  11/32/4  shared single-port datamem address, write data, byte enables.
REQ-010 mem_in  input  32  datamem read data, valid one cycle after address.

Function
REQ-011 Grant is combinational in the request cycle; priority order: (1) pc if lock_q=1 and pc_req; (2) pc if starve_cnt==STARVE_MAX and pc_req; (3) core if core_req; (4) pc if pc_req; (5) none.
REQ-012 At most one of core_gnt/pc_gnt SHALL be 1 in any cycle.
REQ-013 mem_addr/mem_out/mem_wr SHALL mux the granted requester's fields; no grant -> mem_addr=0, mem_out=0, mem_wr=0.
REQ-014 starve_cnt (3-bit min, saturating at STARVE_MAX): +1 when core granted and pc_req=1; cleared when pc granted or pc_req=0.
REQ-015 lock_q: set when pc granted with pc_lock=1; cleared on any edge where pc_req=0 or pc_lock=0; core_req is ignored while lock_q=1 and pc_req=1.
REQ-016 Write protection: pc write (pc_wr!=0) with pc_addr[10]=0 SHALL still be granted but drive mem_wr=0, and pc_err SHALL be 1 in the following cycle for exactly one cycle.
REQ-017 Core has no address restriction.
REQ-018 Read return: x_rvalid registered = x_gnt & (x_wr==0) from the previous cycle; x_rdata = mem_in while x_rvalid=1, else 0.
REQ-019 Write completion is signalled by x_gnt alone; no rvalid for writes.
REQ-020 Simultaneous core_req and pc_req with starve_cnt<STARVE_MAX and lock_q=0 -> core wins, starve_cnt increments.
REQ-021 Requesters SHALL hold request fields stable until granted; the arbiter does not latch ungranted requests.
REQ-022 Throughput: one access per cycle, no idle cycle between grants to different requesters.

Reset
REQ-023 While nrst=1: starve_cnt=0, lock_q=0, core_rvalid=0, pc_rvalid=0, pc_err=0, all grants 0, mem_wr=0, mem_addr=0, mem_out=0, rdata outputs 0.
REQ-024 Reset mid-access: an in-flight read's rvalid SHALL NOT appear after release; first post-reset grant follows REQ-011 with cleared state.
REQ-025 Asserting nrst asynchronously forces all registered outputs to reset values without waiting for clk.

Verification
REQ-026 core_req=1 read addr 0x003, pc_req=0 -> core_gnt=1 same cycle, mem_addr=0x003, mem_wr=0; next cycle core_rvalid=1, core_rdata=mem_in.
REQ-027 core_req and pc_req held continuously, STARVE_MAX=4 -> grant pattern core,core,core,core,pc, repeating; starve_cnt back to 0 after pc grant.
REQ-028 pc_req=1, pc_lock=1 for 3 cycles with core_req=1 throughout (lock taken on first pc grant) -> pc_gnt on all subsequent locked cycles; core granted the cycle after pc_lock drops.
REQ-029 pc write pc_addr=0x002, pc_wr=0xF -> pc_gnt=1, mem_wr=0; next cycle pc_err=1 for one cycle; pc write to 0x401 -> mem_wr=0xF, pc_err=0.
REQ-030 core read granted, nrst pulsed before next clk edge -> core_rvalid stays 0; after release, with only pc_req=1, pc_gnt=1 immediately.
